// File: rtl/max_score_tracker_if.sv
// Width package and valid/ready bundle for max_score_tracker.
// The master side feeds candidates and takes the final best cell.
package design_variables;
  localparam int SCORE_WIDTH    = 16;
  localparam int ROW_BITS_WIDTH = 8;
  localparam int COL_BITS_WIDTH = 8;
endpackage

interface max_score_tracker_if
  import design_variables::*;
#(
  parameter int NUM_BEATS = 31
);
  localparam int CW = $clog2(NUM_BEATS + 1);

  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [SCORE_WIDTH-1:0]    in_score;
  logic [ROW_BITS_WIDTH-1:0] in_row;
  logic [COL_BITS_WIDTH-1:0] in_col;
  logic                      out_valid;
  logic                      out_ready;
  logic [SCORE_WIDTH-1:0]    best_score;
  logic [ROW_BITS_WIDTH-1:0] best_row;
  logic [COL_BITS_WIDTH-1:0] best_col;
  logic [CW-1:0]             beat_cnt;

  modport master (
    output start, in_valid, in_score, in_row, in_col, out_ready,
    input  in_ready, out_valid, best_score, best_row, best_col,
    input  beat_cnt
  );

  modport slave (
    input  start, in_valid, in_score, in_row, in_col, out_ready,
    output in_ready, out_valid, best_score, best_row, best_col,
    output beat_cnt
  );
endinterface

// File: rtl/max_score_tracker.sv
// Running maximum of {score,row,col} over NUM_BEATS wavefront beats.
// MAX_SCORE_TRACKER_IN_REG_EN adds an input register before compare.
module max_score_tracker
  import design_variables::*;
#(
  parameter int NUM_BEATS = 31
) (
  input logic               clk,
  input logic               rst,
  max_score_tracker_if.slave io_bus
);
  localparam int CW = $clog2(NUM_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]             r_cnt;
  logic [SCORE_WIDTH-1:0]    r_best_score;
  logic [ROW_BITS_WIDTH-1:0] r_best_row;
  logic [COL_BITS_WIDTH-1:0] r_best_col;

  logic                      w_acc;
  logic                      w_start;
  logic                      w_hand;
  logic                      w_out_valid;
  logic [CW-1:0]             w_acc_cnt;
  logic                      w_bv;
  logic [SCORE_WIDTH-1:0]    w_bs;
  logic [ROW_BITS_WIDTH-1:0] w_br;
  logic [COL_BITS_WIDTH-1:0] w_bc;

  assign w_acc = io_bus.in_valid && (r_state == TRACK);

`ifdef MAX_SCORE_TRACKER_IN_REG_EN
  logic                      r_v;
  logic [SCORE_WIDTH-1:0]    r_s;
  logic [ROW_BITS_WIDTH-1:0] r_r;
  logic [COL_BITS_WIDTH-1:0] r_c;

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_v <= 1'b0;
      r_s <= '0;
      r_r <= '0;
      r_c <= '0;
    end else begin
      r_v <= w_acc;
      r_s <= io_bus.in_score;
      r_r <= io_bus.in_row;
      r_c <= io_bus.in_col;
    end
  end

  assign w_bv        = r_v;
  assign w_bs        = r_s;
  assign w_br        = r_r;
  assign w_bc        = r_c;
  // A beat still in the register counts toward the final-beat test
  assign w_acc_cnt   = r_cnt + CW'(r_v);
  assign w_out_valid = (r_state == DONE) && !r_v;
`else
  assign w_bv        = w_acc;
  assign w_bs        = io_bus.in_score;
  assign w_br        = io_bus.in_row;
  assign w_bc        = io_bus.in_col;
  assign w_acc_cnt   = r_cnt;
  assign w_out_valid = (r_state == DONE);
`endif

  assign w_hand  = w_out_valid && io_bus.out_ready;
  assign w_start = io_bus.start &&
                   ((r_state == IDLE) || w_hand);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_next = TRACK;
      end
      TRACK: begin
        if (w_acc && (w_acc_cnt == CW'(NUM_BEATS - 1)))
          w_next = DONE;
      end
      DONE: begin
        if (w_start)     w_next = TRACK;
        else if (w_hand) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_cnt        <= '0;
      r_best_score <= '0;
      r_best_row   <= '0;
      r_best_col   <= '0;
    end else if (w_bv) begin
      r_cnt <= r_cnt + 1'b1;
      // Strict compare keeps the earlier beat on ties
      if ((r_cnt == '0) || (w_bs > r_best_score)) begin
        r_best_score <= w_bs;
        r_best_row   <= w_br;
        r_best_col   <= w_bc;
      end
    end
  end

  assign io_bus.in_ready   = (r_state == TRACK);
  assign io_bus.out_valid  = w_out_valid;
  assign io_bus.best_score = r_best_score;
  assign io_bus.best_row   = r_best_row;
  assign io_bus.best_col   = r_best_col;
  assign io_bus.beat_cnt   = r_cnt;
endmodule

// File: doc/max_score_tracker.md
# max_score_tracker

Sequential running-maximum stage that sits directly downstream of the combinational per-wavefront maximum selector. It consumes one {score, row, col} candidate per cycle, keeps the best candidate across all wavefronts of an alignment, and hands the final best cell to the traceback/controller logic over a valid/ready handshake. Widths come from the `design_variables` package: SCORE_WIDTH, ROW_BITS_WIDTH and COL_BITS_WIDTH.

## Interface
- NUM_BEATS, default 31: number of candidate beats per alignment (one per anti-diagonal wavefront); must be ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new alignment; sampled only in IDLE or DONE.
- in_valid  in  1  candidate beat present.
- in_ready  out  1  tracker accepts beats; equals (state == TRACK).
- in_score  in  SCORE_WIDTH  unsigned candidate score.
- in_row  in  ROW_BITS_WIDTH  candidate row.
- in_col  in  COL_BITS_WIDTH  candidate column.
- out_valid  out  1  final result available.
- out_ready  in  1  consumer takes result.
- best_score  out  SCORE_WIDTH  best score of the alignment.
- best_row  out  ROW_BITS_WIDTH  row of best cell.
- best_col  out  COL_BITS_WIDTH  column of best cell.
- beat_cnt  out  $clog2(NUM_BEATS+1)  beats accepted in the current alignment.

## Operation
- FSM states: IDLE, TRACK, DONE. Reset → IDLE.
- IDLE: start=1 → TRACK; best_* cleared to 0; beat_cnt cleared to 0.
- TRACK: beat accepted when in_valid && in_ready. On accept: beat_cnt += 1; if in_score > best_score (strictly greater, unsigned), best_* ← in_*. The first beat always loads best_*, even when its score is 0.
- Tie rule: on equal score the earlier beat is kept, matching the lowest-index-wins rule of the upstream selector.
- When the accepted beat is beat number NUM_BEATS → DONE.
- start while in TRACK is ignored.
- DONE: out_valid=1 and best_* held stable. out_valid && out_ready → IDLE.
- start=1 with out_ready=1 in DONE → TRACK directly, with best_* and beat_cnt cleared.
- start=1 with out_ready=0 in DONE is ignored; the result must not be lost.
- in_valid outside TRACK is ignored; no state change.
- rst mid-alignment aborts it. The next cycle is IDLE with all outputs 0, and no out_valid is produced for the aborted alignment.

## Timing
- Reset values: in_ready=0, out_valid=0, best_score=0, best_row=0, best_col=0, beat_cnt=0.
- start sampled at edge t → in_ready=1 from cycle t+1.
- Without the input register: a beat accepted at edge t is reflected in best_* and beat_cnt after edge t.
- Final beat accepted at edge t → out_valid=1 from cycle t+1; in_ready=0 from cycle t+1.
- Back-to-back beats are accepted every cycle; bubbles (in_valid=0) are allowed anywhere.
- out_valid stays high, with best_* stable, until the handshake completes.

## Configuration
- MAX_SCORE_TRACKER_IN_REG_EN defined:
  - A register stage captures in_valid && in_ready together with in_score/in_row/in_col, to break the long combinational path from the upstream comparator tree.
  - Comparison and counting use the registered copy.
  - Every result latency grows by one cycle: final beat accepted at edge t → out_valid from cycle t+2.
  - in_ready still drops in cycle t+1.
  - The register is cleared by rst and by start.
- Undefined: no register; timing as above.

## Test plan
- Single alignment, NUM_BEATS=4, scores 5,9,3,7 at rows/cols (1,1),(2,3),(4,2),(5,5) back-to-back → best = 9 @ (2,3); out_valid in the cycle after the 4th beat (two cycles after with the macro).
- Tie, NUM_BEATS=3: scores 6@(1,2), 6@(3,4), 2@(0,0) → best = 6 @ (1,2).
- All-zero scores at (7,7), (8,8), … → best = 0 @ (7,7), since the first beat loads.
- Bubbles plus out_ready held low 5 cycles after completion → beat_cnt counts only valid beats; out_valid and best_* remain stable for all 5 cycles; in_valid during DONE is ignored.
- rst asserted after beat 2 of 4 → next cycle IDLE with all outputs 0; a following full alignment reports only its own maximum.
- DONE with start=1 and out_ready=1 → result handed off and the new alignment starts the same edge; in_ready=1 the next cycle with best_*=0.
